reset_sequencer: RTL

//  Sequences release of per-subsystem active-low resets after the global synchronous resetn from the

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all stages, then release them one by one in index order,
// waiting (with timeout) for each stage to acknowledge before releasing the next.

module reset_sequencer_stage (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clr,
   input  logic i_set,
   output logic o_rstn
);
   logic r_rstn;

   // Bits are only ever cleared together, so a released prefix stays contiguous.
   always_ff @(posedge i_clk) begin
      if (!i_resetn || i_clr) r_rstn <= 1'b0;
      else if (i_set)         r_rstn <= 1'b1;
   end

   assign o_rstn = r_rstn;
endmodule

module reset_sequencer #(
   parameter int N_STAGES    = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_DELAY = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_resetn,
   input  logic                          i_sw_rst_req,
   input  logic [N_STAGES-1:0]           i_stage_ack,
   output logic [N_STAGES-1:0]           o_stage_rstn,
   output logic [$clog2(N_STAGES):0]     o_cur_stage,
   output logic                          o_all_ready,
   output logic                          o_seq_error
);
   localparam int CUR_W   = $clog2(N_STAGES) + 1;
   localparam int HD_MAX  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int CNT_MAX = (HD_MAX > TIMEOUT) ? HD_MAX : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {S_HOLD, S_DELAY, S_WAIT_ACK, S_RUN, S_ERROR} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [CUR_W-1:0]    r_cur, w_cur_nxt;
   logic                r_ready, w_ready_nxt;
   logic                r_err, w_err_nxt;
   logic                w_clr;
   logic [N_STAGES-1:0] w_set;
   logic [N_STAGES-1:0] w_stage_rstn;
   logic                w_ack_cur;
   logic                w_last;
   logic                w_ack_all;

   // Select the ack bit of the stage being waited on without an over-wide index.
   always_comb begin
      w_ack_cur = 1'b0;
      for (int k = 0; k < N_STAGES; k++)
         if (r_cur == CUR_W'(k)) w_ack_cur = i_stage_ack[k];
   end

   assign w_last    = (r_cur == CUR_W'(N_STAGES - 1));
   assign w_ack_all = &i_stage_ack;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_cur   <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cur   <= w_cur_nxt;
         r_ready <= w_ready_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cur_nxt   = r_cur;
      w_ready_nxt = r_ready;
      w_err_nxt   = r_err;
      w_clr       = 1'b0;
      w_set       = '0;

      // Software request outranks every event in every state.
      if (i_sw_rst_req) begin
         w_state_nxt = S_HOLD;
         w_cnt_nxt   = '0;
         w_cur_nxt   = '0;
         w_ready_nxt = 1'b0;
         w_err_nxt   = 1'b0;
         w_clr       = 1'b1;
      end else begin
         unique case (r_state)
            S_HOLD: begin
               if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                  w_set[0]    = 1'b1;
                  w_cur_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DELAY;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_DELAY: begin
               if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WAIT_ACK;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_WAIT_ACK: begin
               // An ack on the final timeout edge still counts as in time.
               if (w_ack_cur) begin
                  w_cnt_nxt = '0;
                  if (w_last) begin
                     w_ready_nxt = 1'b1;
                     w_state_nxt = S_RUN;
                  end else begin
                     for (int k = 1; k < N_STAGES; k++)
                        if (r_cur == CUR_W'(k - 1)) w_set[k] = 1'b1;
                     w_cur_nxt   = r_cur + CUR_W'(1);
                     w_state_nxt = S_DELAY;
                  end
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  w_cnt_nxt   = '0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_ERROR;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!w_ack_all) begin
                  w_ready_nxt = 1'b0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_ERROR;
               end
            end
            S_ERROR: begin
               w_state_nxt = S_ERROR;
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_cur_nxt   = '0;
               w_ready_nxt = 1'b0;
               w_err_nxt   = 1'b0;
               w_clr       = 1'b1;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
      reset_sequencer_stage u_stage (
         .i_clk    (i_clk),
         .i_resetn (i_resetn),
         .i_clr    (w_clr),
         .i_set    (w_set[g]),
         .o_rstn   (w_stage_rstn[g])
      );
   end

   assign o_stage_rstn = w_stage_rstn;
   assign o_cur_stage  = r_cur;
   assign o_all_ready  = r_ready;
   assign o_seq_error  = r_err;
endmodule
